// File: rtl/pa_risc_pkg.sv
// Shared PA-RISC front-end constants, the IF/ID payload struct and address helpers.
package pa_risc_pkg;

  localparam int          INSTR_W        = 32;
  localparam logic [31:0] NOP_INSTR      = 32'h0;
  localparam logic [31:0] IAOQ_FRONT_RST = 32'h0;
  localparam logic [31:0] IAOQ_BACK_RST  = 32'h4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        iaoq_front;
    logic [31:0]        iaoq_back;
    logic               valid;
  } ifid_t;

  // Branch targets are word addresses; the low two bits carry no meaning here.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/pa_if_stage_if.sv
// Instruction ROM bus: the fetch stage drives the address, the ROM answers in the same cycle.
interface pa_if_stage_if;
  import pa_risc_pkg::*;

  logic [31:0]        imem_addr;
  logic [INSTR_W-1:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);

endinterface

// File: rtl/pa_iaoq.sv
// Instruction address offset queue: FRONT is the fetch address, BACK the next one.
module pa_iaoq
  import pa_risc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ta_valid,
  input  logic [31:0] ta,
  output logic [31:0] front,
  output logic [31:0] back
);

  logic [31:0] front_nxt;
  logic [31:0] back_nxt;

  // A taken branch only replaces BACK, so the delay-slot instruction at BACK is still fetched.
  always_comb begin
    front_nxt = front;
    back_nxt  = back;
    if (!stall) begin
      front_nxt = back;
      back_nxt  = ta_valid ? align_word(ta) : back + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front <= IAOQ_FRONT_RST;
      back  <= IAOQ_BACK_RST;
    end else begin
      front <= front_nxt;
      back  <= back_nxt;
    end
  end

endmodule

// File: rtl/pa_if_stage.sv
// Fetch stage: IAOQ, ROM address, IF/ID register and optional perf counters (IF_PERF_CNT_EN).
module pa_if_stage
  import pa_risc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                ta_valid,
  input  logic [31:0]         ta,
  input  logic                nullify,
  pa_if_stage_if.master       imem,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [31:0]         id_iaoq_front,
  output logic [31:0]         id_iaoq_back,
  output logic                id_valid,
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         stall_cnt
);

  logic [31:0] front;
  logic [31:0] back;
  ifid_t       ifid_q;
  ifid_t       ifid_d;

  pa_iaoq u_iaoq (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .ta_valid (ta_valid),
    .ta       (ta),
    .front    (front),
    .back     (back)
  );

  assign imem.imem_addr = front;

  // stall is a hold: while high, everything here freezes and ta_valid/nullify are
  // ignored; producers keep them asserted until the cycle stall drops.
  always_comb begin
    ifid_d = ifid_q;
    if (!stall) begin
      ifid_d.instr      = nullify ? NOP_INSTR : imem.imem_data;
      ifid_d.iaoq_front = front;
      ifid_d.iaoq_back  = back;
      ifid_d.valid      = !nullify;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q <= '{instr: NOP_INSTR, iaoq_front: 32'h0, iaoq_back: 32'h0, valid: 1'b0};
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign id_instr      = ifid_q.instr;
  assign id_iaoq_front = ifid_q.iaoq_front;
  assign id_iaoq_back  = ifid_q.iaoq_back;
  assign id_valid      = ifid_q.valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else if (stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign fetch_cnt = 32'h0;
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pa_if_stage.sv
// Self-checking bench for pa_if_stage; counter expectations follow IF_PERF_CNT_EN.
module tb_pa_if_stage;
  import pa_risc_pkg::*;

  localparam int W = 97;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        ta_valid;
  logic [31:0] ta;
  logic        nullify;
  logic [31:0] id_instr;
  logic [31:0] id_iaoq_front;
  logic [31:0] id_iaoq_back;
  logic        id_valid;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  pa_if_stage_if bus ();

  pa_if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .ta_valid      (ta_valid),
    .ta            (ta),
    .nullify       (nullify),
    .imem          (bus.master),
    .id_instr      (id_instr),
    .id_iaoq_front (id_iaoq_front),
    .id_iaoq_back  (id_iaoq_back),
    .id_valid      (id_valid),
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Instruction ROM: a distinct nonzero word per address
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign bus.imem_data = rom(bus.imem_addr);

  // Scoreboard and reference model
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_last;
  logic [31:0]  m_front;
  logic [31:0]  m_back;
  logic [31:0]  m_fc;
  logic [31:0]  m_sc;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_counters();
`ifdef IF_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fc);
    chk("stall_cnt", stall_cnt, m_sc);
`else
    chk("fetch_cnt", fetch_cnt, 32'h0);
    chk("stall_cnt", stall_cnt, 32'h0);
`endif
  endtask

  // Driver: reset for one edge, optionally with a branch resolving in the same cycle
  task automatic do_reset(input logic tv);
    reset    = 1'b1;
    stall    = 1'b0;
    ta_valid = tv;
    ta       = 32'h80;
    nullify  = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    ta_valid = 1'b0;
    m_front  = 32'h0;
    m_back   = 32'h4;
    m_fc     = 32'h0;
    m_sc     = 32'h0;
    m_last   = '0;
    exp_q.delete();
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_front", id_iaoq_front, 32'h0);
    chk("rst_id_back", id_iaoq_back, 32'h0);
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    check_counters();
  endtask

  // Driver: one clock with the given controls; expected IF/ID contents pushed before the edge
  task automatic step(input logic st, input logic tv, input logic [31:0] t, input logic nul);
    logic [W-1:0] e;
    stall    = st;
    ta_valid = tv;
    ta       = t;
    nullify  = nul;
    if (!st) begin
      e       = {(nul ? 32'h0 : rom(m_front)), m_front, m_back, !nul};
      m_front = m_back;
      m_back  = tv ? {t[31:2], 2'b00} : m_back + 32'd4;
      m_fc    = m_fc + 32'd1;
    end else begin
      e    = m_last;
      m_sc = m_sc + 32'd1;
    end
    m_last = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    stall    = 1'b0;
    ta_valid = 1'b0;
    nullify  = 1'b0;
    e = exp_q.pop_front();
    chk("id_instr", id_instr, e[96:65]);
    chk("id_iaoq_front", id_iaoq_front, e[64:33]);
    chk("id_iaoq_back", id_iaoq_back, e[32:1]);
    chk("id_valid", {31'h0, id_valid}, {31'h0, e[0]});
    chk("imem_addr", bus.imem_addr, m_front);
    check_counters();
  endtask

  logic [31:0] a0;

  initial begin
    reset = 1'b1; stall = 1'b0; ta_valid = 1'b0; ta = 32'h0; nullify = 1'b0;
    @(posedge clk);
    #1;

    // Free-running fetch after a one-cycle reset
    do_reset(1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk("seq_addr", bus.imem_addr, 32'(4 * k));
      chk("seq_id_front", id_iaoq_front, 32'(4 * (k - 1)));
      chk("seq_id_valid", {31'h0, id_valid}, 32'h1);
    end

    // Taken branch with delay slot
    do_reset(1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("br_front_pre", bus.imem_addr, 32'h8);
    step(1'b0, 1'b1, 32'h40, 1'b0);
    chk("br_delay_slot", bus.imem_addr, 32'hC);
    chk("br_id_back", id_iaoq_back, 32'hC);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("br_target", bus.imem_addr, 32'h40);
    chk("br_back_latched", id_iaoq_back, 32'h40);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("br_target_plus4", bus.imem_addr, 32'h44);
    chk("br_back_plus4", id_iaoq_back, 32'h44);

    // Misaligned target together with nullify
    step(1'b0, 1'b1, 32'h43, 1'b1);
    chk("nul_instr", id_instr, 32'h0);
    chk("nul_valid", {31'h0, id_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("align_target", bus.imem_addr, 32'h40);

    // Three-cycle stall with a branch pulse that must be ignored
    a0 = bus.imem_addr;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h200, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("stall_hold", bus.imem_addr, a0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_resume", bus.imem_addr, a0 + 32'd4);

    // Address wrap at the top of the space
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_front_f8", bus.imem_addr, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_front_fc", bus.imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_front_0", bus.imem_addr, 32'h0);
    chk("wrap_id_back", id_iaoq_back, 32'h0);

    // Reset while a branch is in flight: no target survives
    step(1'b0, 1'b1, 32'h300, 1'b0);
    do_reset(1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_br_addr", bus.imem_addr, 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rst_br_addr2", bus.imem_addr, 32'h8);

    // Counters: 5 run cycles then 3 stall cycles, plus randomized traffic
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("cnt_fetch5", fetch_cnt, 32'd5);
    chk("cnt_stall3", stall_cnt, 32'd3);
`else
    chk("cnt_fetch_off", fetch_cnt, 32'h0);
    chk("cnt_stall_off", stall_cnt, 32'h0);
`endif
    for (int k = 0; k < 40; k++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
           32'($urandom), 1'($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
